rx_chain_mc_model: RTL and testbench

Multi-channel, parametrised successor of the single-channel RX chain model used in the top-level simulation model.
- Takes NCH independent I/Q sample streams, for example loopback of the TX outputs.
- Decimates each stream by a runtime-programmable rate using a boxcar accumulator.
- Buffers the decimated results per channel in a FIFO that supports backpressure.
- Presents the results to the flocra core RX ports as 64-bit AXI-stream words.
- Adds sticky overflow detection, which the single-channel model lacks.

---
 rtl/rx_chain_mc_model.sv | 169 ++++++++++++++++
 tb/tb_rx_chain_mc_model.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_chain_mc_model.sv
`default_nettype none
// ============================================================================
//  Module   : rx_chain_mc_model
//  Purpose  : Multi-channel RX chain model. Each channel decimates an I/Q
//             stream with a boxcar accumulator and buffers the sums in a
//             first-word-fall-through FIFO with backpressure and a sticky
//             overflow flag. Output words are {Q_sum, I_sum}.
//  Options  : RX_CHAIN_MC_SHIFT_EN - arithmetic right shift of each pushed
//             sum by the channel's config bits [15:12].
//  Revision : 1.0 - initial release
// ============================================================================
module rx_chain_mc_model #(
    parameter int NCH        = 2,
    parameter int IN_W       = 16,
    parameter int ACC_W      = 32,
    parameter int RATE_W     = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH*16-1:0]       rate_axis_tdata_i,
    input  logic [NCH-1:0]          rate_axis_tvalid_i,
    input  logic [NCH*2*IN_W-1:0]   rx_iq_axis_tdata_i,
    input  logic [NCH-1:0]          rx_iq_axis_tvalid_i,
    output logic [NCH*2*ACC_W-1:0]  axis_tdata_o,
    output logic [NCH-1:0]          axis_tvalid_o,
    input  logic [NCH-1:0]          axis_tready_i,
    output logic [NCH-1:0]          overflow_o
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_WW = 2 * ACC_W;

    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_ch
            logic [15:0]           w_cfg;
            logic                  w_cfg_v;
            logic [IN_W-1:0]       w_in_i;
            logic [IN_W-1:0]       w_in_q;
            logic                  w_in_v;
            logic [ACC_W-1:0]      w_sum_i;
            logic [ACC_W-1:0]      w_sum_q;
            logic [ACC_W-1:0]      w_push_i;
            logic [ACC_W-1:0]      w_push_q;
            logic                  w_take;
            logic                  w_last;
            logic                  w_push;
            logic                  w_empty;
            logic                  w_full;
            logic                  w_pop;
            logic                  w_wr;

            logic [RATE_W-1:0]     r_rate;
            logic [RATE_W-1:0]     r_cnt;
            logic [ACC_W-1:0]      r_acc_i;
            logic [ACC_W-1:0]      r_acc_q;
            logic [c_WW-1:0]       r_mem [FIFO_DEPTH];
            logic [c_AW:0]         r_wptr;
            logic [c_AW:0]         r_rptr;
            logic                  r_ovf;

            assign w_cfg   = rate_axis_tdata_i[c*16 +: 16];
            assign w_cfg_v = rate_axis_tvalid_i[c];
            assign w_in_i  = rx_iq_axis_tdata_i[c*2*IN_W +: IN_W];
            assign w_in_q  = rx_iq_axis_tdata_i[c*2*IN_W + IN_W +: IN_W];
            assign w_in_v  = rx_iq_axis_tvalid_i[c];

            // Running sums including the current sample (sign-extended)
            assign w_sum_i = r_acc_i + {{(ACC_W-IN_W){w_in_i[IN_W-1]}}, w_in_i};
            assign w_sum_q = r_acc_q + {{(ACC_W-IN_W){w_in_q[IN_W-1]}}, w_in_q};

            // A config write in the same cycle swallows the sample
            assign w_take  = w_in_v && !w_cfg_v && (r_rate != '0);
            assign w_last  = (r_cnt == r_rate - RATE_W'(1));
            assign w_push  = w_take && w_last;

            assign w_empty = (r_wptr == r_rptr);
            assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                             (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
            assign w_pop   = !w_empty && axis_tready_i[c];
            // A full FIFO still accepts when a pop frees a slot this cycle
            assign w_wr    = w_push && (!w_full || w_pop);

`ifdef RX_CHAIN_MC_SHIFT_EN
            logic [3:0] r_shift;

            assign w_push_i = $signed(w_sum_i) >>> r_shift;
            assign w_push_q = $signed(w_sum_q) >>> r_shift;

            // Shift amount is latched alongside the rate
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_shift <= '0;
                end else if (w_cfg_v) begin
                    r_shift <= w_cfg[15:12];
                end
            end
`else
            logic w_unused_cfg;

            assign w_push_i     = w_sum_i;
            assign w_push_q     = w_sum_q;
            assign w_unused_cfg = ^w_cfg[15:RATE_W];
`endif

            // Rate register, sample counter and boxcar accumulators
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rate  <= '0;
                    r_cnt   <= '0;
                    r_acc_i <= '0;
                    r_acc_q <= '0;
                end else if (w_cfg_v) begin
                    r_rate  <= w_cfg[RATE_W-1:0];
                    r_cnt   <= '0;
                    r_acc_i <= '0;
                    r_acc_q <= '0;
                end else if (w_take) begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_acc_i <= '0;
                        r_acc_q <= '0;
                    end else begin
                        r_cnt   <= r_cnt + RATE_W'(1);
                        r_acc_i <= w_sum_i;
                        r_acc_q <= w_sum_q;
                    end
                end
            end

            // FIFO storage and pointers; pointers carry an extra wrap bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < FIFO_DEPTH; k++) begin
                        r_mem[k] <= '0;
                    end
                    r_wptr <= '0;
                    r_rptr <= '0;
                end else begin
                    if (w_wr) begin
                        r_mem[r_wptr[c_AW-1:0]] <= {w_push_q, w_push_i};
                        r_wptr                  <= r_wptr + (c_AW+1)'(1);
                    end
                    if (w_pop) begin
                        r_rptr <= r_rptr + (c_AW+1)'(1);
                    end
                end
            end

            // Sticky overflow: set on a dropped word, cleared by a config write
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_cfg_v) begin
                    r_ovf <= 1'b0;
                end else if (w_push && w_full && !w_pop) begin
                    r_ovf <= 1'b1;
                end
            end

            assign axis_tdata_o[c*c_WW +: c_WW] = r_mem[r_rptr[c_AW-1:0]];
            assign axis_tvalid_o[c]             = !w_empty;
            assign overflow_o[c]                = r_ovf;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rx_chain_mc_model.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_chain_mc_model
//  Purpose  : Self-checking bench for rx_chain_mc_model: directed scenarios
//             with literal expectations plus randomized traffic compared
//             each cycle against a behavioural per-channel model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rx_chain_mc_model;

    localparam int NCH        = 2;
    localparam int IN_W       = 16;
    localparam int ACC_W      = 32;
    localparam int RATE_W     = 12;
    localparam int FIFO_DEPTH = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NCH*16-1:0]      rate_td = '0;
    logic [NCH-1:0]         rate_tv = '0;
    logic [NCH*2*IN_W-1:0]  iq_td = '0;
    logic [NCH-1:0]         iq_tv = '0;
    logic [NCH*2*ACC_W-1:0] out_td;
    logic [NCH-1:0]         out_tv;
    logic [NCH-1:0]         tready = '0;
    logic [NCH-1:0]         ovf;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int                 m_rate [NCH];
    int                 m_shift[NCH];
    int                 m_n    [NCH];
    logic signed [31:0] m_si   [NCH];
    logic signed [31:0] m_sq   [NCH];
    logic [63:0]        m_q    [NCH][FIFO_DEPTH];
    int                 m_cnt  [NCH];
    logic               m_ovf  [NCH];

    rx_chain_mc_model #(
        .NCH(NCH), .IN_W(IN_W), .ACC_W(ACC_W), .RATE_W(RATE_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rate_axis_tdata_i  (rate_td),
        .rate_axis_tvalid_i (rate_tv),
        .rx_iq_axis_tdata_i (iq_td),
        .rx_iq_axis_tvalid_i(iq_tv),
        .axis_tdata_o       (out_td),
        .axis_tvalid_o      (out_tv),
        .axis_tready_i      (tready),
        .overflow_o         (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_rate[c] = 0; m_shift[c] = 0; m_n[c] = 0;
            m_si[c] = '0; m_sq[c] = '0; m_cnt[c] = 0; m_ovf[c] = 1'b0;
            for (int k = 0; k < FIFO_DEPTH; k++) m_q[c][k] = '0;
        end
    endtask

    // Next state of every channel from the inputs presented for this edge
    task automatic model_step();
        logic [15:0]        cw;
        logic signed [15:0] si, sq;
        logic signed [31:0] wi, wq;
        logic               pop, push;
        logic [63:0]        word;
        for (int c = 0; c < NCH; c++) begin
            cw   = rate_td[c*16 +: 16];
            si   = iq_td[c*32 +: 16];
            sq   = iq_td[c*32+16 +: 16];
            pop  = (m_cnt[c] > 0) && tready[c];
            push = 1'b0;
            word = '0;
            if (rate_tv[c]) begin
                m_rate[c]  = int'(cw[11:0]);
                m_shift[c] = int'(cw[15:12]);
                m_n[c] = 0; m_si[c] = '0; m_sq[c] = '0; m_ovf[c] = 1'b0;
            end else if (m_rate[c] != 0 && iq_tv[c]) begin
                m_si[c] = m_si[c] + si;
                m_sq[c] = m_sq[c] + sq;
                m_n[c]++;
                if (m_n[c] == m_rate[c]) begin
`ifdef RX_CHAIN_MC_SHIFT_EN
                    wi = m_si[c] >>> m_shift[c];
                    wq = m_sq[c] >>> m_shift[c];
`else
                    wi = m_si[c];
                    wq = m_sq[c];
`endif
                    word = {wq, wi};
                    push = 1'b1;
                    m_n[c] = 0; m_si[c] = '0; m_sq[c] = '0;
                end
            end
            if (pop) begin
                for (int k = 0; k < FIFO_DEPTH-1; k++) m_q[c][k] = m_q[c][k+1];
                m_cnt[c]--;
            end
            if (push) begin
                if (m_cnt[c] < FIFO_DEPTH) begin
                    m_q[c][m_cnt[c]] = word;
                    m_cnt[c]++;
                end else begin
                    m_ovf[c] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_model();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("tvalid[%0d]", c), 64'(out_tv[c]), 64'(m_cnt[c] > 0));
            chk($sformatf("overflow[%0d]", c), 64'(ovf[c]), 64'(m_ovf[c]));
            if (m_cnt[c] > 0)
                chk($sformatf("tdata[%0d]", c), out_td[c*64 +: 64], m_q[c][0]);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
        rate_tv = '0;
        iq_tv   = '0;
    endtask

    task automatic set_cfg(input int c, input logic [15:0] w);
        rate_td[c*16 +: 16] = w;
        rate_tv[c] = 1'b1;
    endtask

    task automatic set_smp(input int c, input logic [15:0] i, input logic [15:0] q);
        iq_td[c*32 +: 32] = {q, i};
        iq_tv[c] = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset tvalid", 64'(out_tv), 64'd0);
        chk("reset tdata0", out_td[63:0], 64'd0);
        chk("reset ovf", 64'(ovf), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tready = '1;

        // Decimate by 4 on ch0
        set_cfg(0, 16'h0004); tick();
        for (int k = 1; k <= 8; k++) begin
            set_smp(0, 16'd100, 16'hFFFD); tick();
            if (k == 3) chk("dec4 early", 64'(out_tv[0]), 64'd0);
            if (k == 4 || k == 8) begin
                chk("dec4 valid", 64'(out_tv[0]), 64'd1);
                chk("dec4 word", out_td[63:0], 64'hFFFF_FFF4_0000_0190);
            end
            if (k == 5) chk("dec4 popped", 64'(out_tv[0]), 64'd0);
        end

        // Rate 1 on ch1, ch0 idle
        set_cfg(0, 16'h0000); set_cfg(1, 16'h0001); tick();
        for (int k = 5; k <= 7; k++) begin
            set_smp(1, 16'(k), 16'd0); set_smp(0, 16'd9, 16'd9); tick();
            chk("rate1 I", out_td[64 +: 64], 64'(k));
            chk("ch0 idle", 64'(out_tv[0]), 64'd0);
        end
        tick();

        // Fill ch1 to capacity without draining
        tready[1] = 1'b0;
        for (int k = 1; k <= 16; k++) begin set_smp(1, 16'(k), 16'd0); tick(); end
        chk("full no ovf", 64'(ovf[1]), 64'd0);
        chk("full head", out_td[64 +: 64], 64'd1);
        tready[1] = 1'b1; set_smp(1, 16'd17, 16'd0); tick();
        chk("push+pop no ovf", 64'(ovf[1]), 64'd0);
        chk("push+pop head", out_td[64 +: 64], 64'd2);
        tready[1] = 1'b0; set_smp(1, 16'd18, 16'd0); tick();
        chk("ovf set", 64'(ovf[1]), 64'd1);
        tready[1] = 1'b1;
        for (int k = 0; k < 17; k++) tick();
        set_cfg(1, 16'h0001); tick();
        chk("ovf cleared", 64'(ovf[1]), 64'd0);

        // Partial sum is discarded by a rate rewrite
        set_cfg(0, 16'h0003); tick();
        for (int k = 0; k < 2; k++) begin set_smp(0, 16'd1, 16'd0); tick(); end
        set_cfg(0, 16'h0002); tick();
        set_smp(0, 16'd1, 16'd0); tick();
        chk("rewrite none", 64'(out_tv[0]), 64'd0);
        set_smp(0, 16'd1, 16'd0); tick();
        chk("rewrite word", out_td[63:0], 64'd2);
        tick();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < NCH; c++) begin
                tready[c] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 49) == 0)
                    set_cfg(c, {4'($urandom_range(0, 15)), 12'($urandom_range(0, 5))});
                if ($urandom_range(0, 9) < 7)
                    set_smp(c, 16'($urandom), 16'($urandom));
            end
            tick();
        end
        tready = '1;
        for (int k = 0; k < 20; k++) tick();

`ifdef RX_CHAIN_MC_SHIFT_EN
        set_cfg(0, 16'h2004); tick();
        for (int k = 0; k < 4; k++) begin set_smp(0, 16'hFFF9, 16'd0); tick(); end
        chk("shift word", out_td[63:0], 64'h0000_0000_FFFF_FFF9);
        tick();
`endif

        // Asynchronous reset with words in flight
        tready = '0;
        set_cfg(1, 16'h0001); tick();
        for (int k = 0; k < 3; k++) begin set_smp(1, 16'd7, 16'd7); tick(); end
        #2 rst_n = 1'b0;
        #1;
        chk("async tvalid", 64'(out_tv), 64'd0);
        chk("async tdata1", out_td[64 +: 64], 64'd0);
        chk("async ovf", 64'(ovf), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        tready = '1;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
